// File: rtl/lsu_hs_if.sv
// lsu_hs_if: EXU request/response and memory-bus signals of the load/store unit.
// The slave modport is the LSU's view; the master modport is the surrounding
// EXU plus memory environment.
interface lsu_hs_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // EXU request channel
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_wen;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  // EXU response channel
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_err;
  // Memory bus
  logic                  bus_valid;
  logic                  bus_ready;
  logic                  bus_wen;
  logic [ADDR_W-1:0]     bus_addr;
  logic [DATA_W-1:0]     bus_wdata;
  logic [DATA_W/8-1:0]   bus_wmask;
  logic                  bus_rvalid;
  logic [DATA_W-1:0]     bus_rdata;

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output bus_valid, bus_wen, bus_addr, bus_wdata, bus_wmask,
    input  bus_ready, bus_rvalid, bus_rdata
  );

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  bus_valid, bus_wen, bus_addr, bus_wdata, bus_wmask,
    output bus_ready, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/lsu_hs.sv
// lsu_hs: handshaked multi-cycle load/store unit. Accepts one EXU request at a
// time, sizes and lane-aligns it onto a valid/ready memory bus, and returns
// sign/zero-extended load data. Misaligned or illegally sized requests are
// answered with resp_err without any bus access.
// Optional: define LSU_TIMEOUT_EN to add a bus-response timeout (TIMEOUT cycles).
module lsu_hs #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
`ifdef LSU_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input logic      clk,
  input logic      rst,
  lsu_hs_if.slave  lsu
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        state_q,     state_d;
  logic              wen_q,       wen_d;
  logic              uns_q,       uns_d;
  logic [1:0]        size_q,      size_d;
  logic [OFF_W-1:0]  off_q,       off_d;
  logic              bus_wen_q,   bus_wen_d;
  logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [NB-1:0]     bus_wmask_q, bus_wmask_d;
  logic [DATA_W-1:0] rdata_q,     rdata_d;
  logic              err_q,       err_d;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

  // Incoming request decode: legality, lane offset, byte mask and shifted data
  logic [OFF_W-1:0]  req_off;
  logic              req_bad;
  logic              req_mis;
  logic [NB-1:0]     req_base_mask;
  logic [NB-1:0]     req_wmask;
  logic [DATA_W-1:0] req_wdata_sh;

  assign req_off = lsu.req_addr[OFF_W-1:0];

  // Size-dependent alignment check and byte-enable pattern for the new request
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case can leave it unassigned and infer a latch.
    req_mis       = 1'b0;
    req_base_mask = '0;
    unique case (lsu.req_size)
      2'd0: begin req_mis = 1'b0;                 req_base_mask = NB'(8'h01); end
      2'd1: begin req_mis = lsu.req_addr[0];      req_base_mask = NB'(8'h03); end
      2'd2: begin req_mis = |lsu.req_addr[1:0];   req_base_mask = NB'(8'h0F); end
      2'd3: begin req_mis = |lsu.req_addr[2:0];   req_base_mask = NB'(8'hFF); end
    endcase
  end

  assign req_bad      = req_mis || ((lsu.req_size == 2'd3) && (DATA_W != 64));
  assign req_wmask    = req_base_mask << req_off;
  assign req_wdata_sh = lsu.req_wdata << {req_off, 3'b000};

  // Returned bus data moved down to bit 0, then truncated and extended
  logic [DATA_W-1:0] rd_sh;
  logic [DATA_W-1:0] load_ext;
  logic              fill;
  int                nbits;

  assign rd_sh = lsu.bus_rdata >> {off_q, 3'b000};

  // Size-dependent extension of the load result
  always_comb begin
    nbits = 8 << size_q;
    fill  = 1'b0;
    unique case (size_q)
      2'd0:    fill = rd_sh[7];
      2'd1:    fill = rd_sh[15];
      2'd2:    fill = rd_sh[31];
      default: fill = rd_sh[DATA_W-1];
    endcase
    fill = fill & ~uns_q;
    for (int i = 0; i < DATA_W; i++) begin
      load_ext[i] = (i < nbits) ? rd_sh[i] : fill;
    end
  end

  // Next-state logic for the request/bus/response sequence
  always_comb begin
    state_d     = state_q;
    wen_d       = wen_q;
    uns_d       = uns_q;
    size_d      = size_q;
    off_d       = off_q;
    bus_wen_d   = bus_wen_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wmask_d = bus_wmask_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (lsu.req_valid) begin
          wen_d  = lsu.req_wen;
          uns_d  = lsu.req_unsigned;
          size_d = lsu.req_size;
          off_d  = req_off;
          if (req_bad) begin
            // Rejected without touching the bus; bus outputs keep their values
            state_d = S_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d     = S_REQ;
            err_d       = 1'b0;
            bus_wen_d   = lsu.req_wen;
            bus_addr_d  = {lsu.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            bus_wdata_d = req_wdata_sh;
            bus_wmask_d = lsu.req_wen ? req_wmask : '0;
`ifdef LSU_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end
        end
      end
      S_REQ: begin
        if (lsu.bus_ready) begin
          if (lsu.bus_rvalid) begin
            state_d = S_RESP;
            rdata_d = wen_q ? '0 : load_ext;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (lsu.bus_rvalid) begin
          state_d = S_RESP;
          rdata_d = wen_q ? '0 : load_ext;
        end
      end
      S_RESP: begin
        if (lsu.resp_ready) state_d = S_IDLE;
      end
    endcase

`ifdef LSU_TIMEOUT_EN
    // A real response in the same cycle wins over the timeout
    if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
      cnt_d = cnt_q + 1'b1;
      if ((state_d != S_RESP) && (cnt_d == CNT_W'(TIMEOUT))) begin
        state_d = S_RESP;
        err_d   = 1'b1;
        rdata_d = '0;
      end
    end
`endif
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wen_q       <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'd0;
      off_q       <= '0;
      bus_wen_q   <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wmask_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q     <= state_d;
      wen_q       <= wen_d;
      uns_q       <= uns_d;
      size_q      <= size_d;
      off_q       <= off_d;
      bus_wen_q   <= bus_wen_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wmask_q <= bus_wmask_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign lsu.req_ready  = (state_q == S_IDLE);
  assign lsu.resp_valid = (state_q == S_RESP);
  assign lsu.resp_rdata = rdata_q;
  assign lsu.resp_err   = err_q;
  assign lsu.bus_valid  = (state_q == S_REQ);
  assign lsu.bus_wen    = bus_wen_q;
  assign lsu.bus_addr   = bus_addr_q;
  assign lsu.bus_wdata  = bus_wdata_q;
  assign lsu.bus_wmask  = bus_wmask_q;

endmodule

// File: tb/tb_lsu_hs.sv
// tb_lsu_hs: self-checking bench for lsu_hs (ADDR_W = DATA_W = 32). Expected
// values come from a byte-level reference model of the load/store rules.
`timescale 1ns/1ps
module tb_lsu_hs;

`ifdef LSU_TIMEOUT_EN
  localparam int TMO = 4;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  lsu_hs_if #(.ADDR_W(32), .DATA_W(32)) io ();

`ifdef LSU_TIMEOUT_EN
  lsu_hs #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .lsu(io));
`else
  lsu_hs #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .lsu(io));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: access outcome computed byte by byte from the request
  function automatic void model(input logic [31:0] addr, input logic [1:0] size,
                                input logic [31:0] wdata, input logic wen,
                                input logic uns, input logic [31:0] rdata,
                                output logic err, output logic [31:0] r,
                                output logic [31:0] baddr, output logic [31:0] wd,
                                output logic [3:0] mask);
    longint unsigned n, off, v, lim;
    n     = longint'(1) << size;
    off   = addr % 4;
    err   = (size == 2'd3) || ((addr % n) != 0);
    baddr = addr - 32'(off);
    mask  = 4'b0000;
    if (wen) for (int b = 0; b < 4; b++) if (b >= off && b < off + n) mask[b] = 1'b1;
    wd    = 32'((longint'(wdata) * (longint'(1) << (8 * off))) % (longint'(1) << 32));
    lim   = longint'(1) << (8 * n);
    v     = (longint'(rdata) / (longint'(1) << (8 * off))) % lim;
    if (!uns && v >= lim / 2) v = v + (longint'(1) << 32) - lim;
    r     = (wen || err) ? 32'd0 : 32'(v);
  endfunction

  task automatic idle_inputs();
    io.req_valid = 1'b0; io.req_wen = 1'b0; io.req_addr = '0; io.req_wdata = '0;
    io.req_size = 2'd0; io.req_unsigned = 1'b0; io.resp_ready = 1'b0;
    io.bus_ready = 1'b0; io.bus_rvalid = 1'b0; io.bus_rdata = '0;
  endtask

  // One complete transaction with configurable bus/response stalls
  task automatic do_txn(input string nm, input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wdata, input logic wen, input logic uns,
                        input logic [31:0] rdata, input int bus_dly, input int rv_dly,
                        input int resp_dly);
    logic e_err; logic [31:0] e_r, e_ba, e_wd; logic [3:0] e_m;
    model(addr, size, wdata, wen, uns, rdata, e_err, e_r, e_ba, e_wd, e_m);
    io.req_valid = 1'b1; io.req_addr = addr; io.req_size = size;
    io.req_wdata = wdata; io.req_wen = wen; io.req_unsigned = uns;
    @(negedge clk);
    n_checks++;
    if (io.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s req_ready_idle: got %b want 1", nm, io.req_ready);
    end
    @(posedge clk); #1;
    io.req_valid = 1'b0; io.req_addr = $urandom; io.req_wdata = $urandom;
    io.req_size = 2'($urandom); io.req_wen = 1'($urandom);
    if (!e_err) begin
      for (int i = 0; i <= bus_dly; i++) begin
        if (i == bus_dly) begin
          io.bus_ready = 1'b1;
          if (rv_dly == 0) begin io.bus_rvalid = 1'b1; io.bus_rdata = rdata; end
        end
        @(negedge clk);
        n_checks++;
        if ({io.bus_valid, io.bus_wen, io.bus_addr, io.bus_wmask, io.req_ready, io.resp_valid}
            !== {1'b1, wen, e_ba, e_m, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL %s bus_req cyc%0d: got v=%b w=%b a=%h m=%b rr=%b rv=%b want v=1 w=%b a=%h m=%b rr=0 rv=0",
                   nm, i, io.bus_valid, io.bus_wen, io.bus_addr, io.bus_wmask, io.req_ready,
                   io.resp_valid, wen, e_ba, e_m);
        end
        if (wen) begin
          n_checks++;
          if (io.bus_wdata !== e_wd) begin
            n_fail++; $display("FAIL %s bus_wdata cyc%0d: got %h want %h", nm, i, io.bus_wdata, e_wd);
          end
        end
        @(posedge clk); #1;
        io.bus_ready = 1'b0; io.bus_rvalid = 1'b0; io.bus_rdata = $urandom;
      end
      for (int i = 1; i <= rv_dly; i++) begin
        if (i == rv_dly) begin io.bus_rvalid = 1'b1; io.bus_rdata = rdata; end
        @(negedge clk);
        n_checks++;
        if ({io.bus_valid, io.resp_valid, io.req_ready} !== 3'b000) begin
          n_fail++;
          $display("FAIL %s wait cyc%0d: got bv=%b rv=%b rr=%b want 000", nm, i,
                   io.bus_valid, io.resp_valid, io.req_ready);
        end
        @(posedge clk); #1;
        io.bus_rvalid = 1'b0; io.bus_rdata = $urandom;
      end
    end
    for (int i = 0; i <= resp_dly; i++) begin
      io.resp_ready = (i == resp_dly);
      @(negedge clk);
      n_checks++;
      if ({io.resp_valid, io.resp_err, io.resp_rdata, io.req_ready, io.bus_valid}
          !== {1'b1, e_err, e_r, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL %s resp cyc%0d: got v=%b err=%b d=%h rr=%b bv=%b want v=1 err=%b d=%h rr=0 bv=0",
                 nm, i, io.resp_valid, io.resp_err, io.resp_rdata, io.req_ready, io.bus_valid,
                 e_err, e_r);
      end
      @(posedge clk); #1;
      io.resp_ready = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if ({io.req_ready, io.resp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL %s back_to_idle: got rr=%b rv=%b want rr=1 rv=0", nm,
                         io.req_ready, io.resp_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_vals(input string nm);
    n_checks++;
    if ({io.req_ready, io.resp_valid, io.resp_err, io.resp_rdata, io.bus_valid, io.bus_wen,
         io.bus_addr, io.bus_wdata, io.bus_wmask} !== {1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0,
         32'd0, 32'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL %s reset_values: got rr=%b rv=%b err=%b d=%h bv=%b bw=%b a=%h wd=%h m=%b want rr=1 rest 0",
               nm, io.req_ready, io.resp_valid, io.resp_err, io.resp_rdata, io.bus_valid,
               io.bus_wen, io.bus_addr, io.bus_wdata, io.bus_wmask);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #12;
    check_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("after_reset");
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_txn("word_load",   32'h8000_0004, 2'd2, 32'h0,         1'b0, 1'b0, 32'hDEAD_BEEF, 0, 0, 0);
    do_txn("sbyte_load",  32'h8000_0003, 2'd0, 32'h0,         1'b0, 1'b0, 32'h85FF_1234, 0, 0, 0);
    do_txn("ubyte_load",  32'h8000_0003, 2'd0, 32'h0,         1'b0, 1'b1, 32'h85FF_1234, 0, 0, 0);
    do_txn("half_store",  32'h8000_0002, 2'd1, 32'h0000_ABCD, 1'b1, 1'b0, 32'h1234_5678, 0, 1, 0);
    do_txn("shalf_load",  32'h8000_0002, 2'd1, 32'h0,         1'b0, 1'b0, 32'h8001_0000, 0, 2, 0);
  endtask

  task automatic test_misaligned();
    do_txn("mis_half",    32'h8000_0001, 2'd1, 32'h0,         1'b0, 1'b0, 32'h0, 0, 0, 0);
    do_txn("mis_word",    32'h8000_0002, 2'd2, 32'h1111_2222, 1'b1, 1'b0, 32'h0, 0, 0, 1);
    do_txn("illegal_dw",  32'h8000_0008, 2'd3, 32'h0,         1'b0, 1'b0, 32'h0, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    do_txn("bp_store",    32'h8000_0010, 2'd2, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0,         3, 1, 2);
    do_txn("bp_load",     32'h8000_0011, 2'd0, 32'h0,         1'b0, 1'b0, 32'h0000_7F00, 3, 0, 2);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      do_txn("rand", 32'h8000_0000 + $urandom_range(0, 63), 2'($urandom_range(0, 3)), $urandom,
             1'($urandom), 1'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 2));
    end
  endtask

  task automatic test_rst_abort();
    io.req_valid = 1'b1; io.req_addr = 32'h8000_0020; io.req_size = 2'd2;
    io.req_wen = 1'b0; io.req_unsigned = 1'b0;
    @(posedge clk); #1;
    io.req_valid = 1'b0; io.bus_ready = 1'b1;
    @(posedge clk); #1;
    io.bus_ready = 1'b0;
    @(negedge clk); #1;
    rst = 1'b1;
    #2;
    check_reset_vals("rst_abort");
    @(posedge clk); #1;
    rst = 1'b0;
    io.bus_rvalid = 1'b1; io.bus_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    io.bus_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({io.resp_valid, io.req_ready, io.bus_valid} !== 3'b010) begin
        n_fail++; $display("FAIL late_rvalid cyc%0d: got rv=%b rr=%b bv=%b want rv=0 rr=1 bv=0",
                           i, io.resp_valid, io.req_ready, io.bus_valid);
      end
    end
    @(posedge clk); #1;
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    io.req_valid = 1'b1; io.req_addr = 32'h8000_0030; io.req_size = 2'd2;
    io.req_wen = 1'b0; io.req_unsigned = 1'b0;
    @(posedge clk); #1;
    io.req_valid = 1'b0; io.bus_ready = 1'b1;
    @(posedge clk); #1;
    io.bus_ready = 1'b0;
    cyc = 0;
    while (io.resp_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if ({io.resp_valid, io.resp_err, io.resp_rdata} !== {1'b1, 1'b1, 32'd0}) begin
      n_fail++; $display("FAIL timeout: got rv=%b err=%b d=%h after %0d cycles want rv=1 err=1 d=0",
                         io.resp_valid, io.resp_err, io.resp_rdata, cyc);
    end
    io.resp_ready = 1'b1;
    @(posedge clk); #1;
    io.resp_ready = 1'b0; io.bus_rvalid = 1'b1;
    @(posedge clk); #1;
    io.bus_rvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({io.resp_valid, io.req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL timeout_drop: got rv=%b rr=%b want rv=0 rr=1", io.resp_valid, io.req_ready);
    end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_misaligned();
    test_backpressure();
    test_random();
    test_rst_abort();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
